viterbi_chan_inj: RTL and testbench
===================================

Name: viterbi_chan_inj

Overview:
- Parametrised channel model between the convolutional encoder and the Viterbi decoder.
- Registers each encoded symbol and optionally flips bits: clean, random (LFSR, programmable rate), periodic burst, or single forced error.
- Keeps saturating symbol and flipped-bit counters so the test harness can correlate decoder failures with channel damage.
- Supersedes the hard-wired, single-rate error injection in the tx/rx harness.

Parameters:
- SYM_W, 2, bits per encoded symbol (code rate 1/SYM_W).
- LFSR_W, 32, LFSR width; fixed polynomial x^32+x^22+x^2+x+1 when 32; other widths take a polynomial constant from the package.
- SEED, 32'hACE1_2468, LFSR reset value; 0 is replaced by 1.
- RATE_W, 5, width of the rate select.
- CNT_W, 16, width of the statistics counters.
- LEN_W, 8, width of the burst length/gap fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- mode_i  in  2  0 clean, 1 random, 2 burst, 3 single-shot
- rate_i  in  RATE_W  random mode: inject when lfsr[rate_i-1:0] is all ones; rate_i=0 means every symbol
- burst_len_i  in  LEN_W  burst mode: erroneous symbols per burst (0 = no errors)
- burst_gap_i  in  LEN_W  burst mode: clean symbols between bursts
- shot_i  in  1  single-shot request pulse
- valid_i  in  1  input symbol valid
- sym_i  in  SYM_W  encoder symbol
- clr_stats_i  in  1  synchronous clear of counters
- valid_o  out  1  output symbol valid
- sym_o  out  SYM_W  channel output symbol
- err_o  out  SYM_W  mask applied to the current sym_o
- sym_ct_o  out  CNT_W  symbols passed
- bad_bit_ct_o  out  CNT_W  bits flipped

Behaviour:
- Reset: all outputs 0; LFSR=SEED; FSM=S_CLEAN; burst counters 0; shot pending flag 0.
- Latency: exactly 1 cycle. valid_o(t+1)=valid_i(t); sym_o(t+1)=sym_i(t)^mask(t); err_o(t+1)=mask(t).
- When valid_i=0: sym_o and err_o hold, and LFSR, FSM and counters are frozen.
- LFSR: Galois, advances one step per valid_i.
  - raw = top SYM_W bits of the current state.
  - nzmask = raw, or 1 in the LSB if raw is all zeros.
- FSM states: S_CLEAN, S_RAND, S_GAP, S_BURST. On each valid_i, the next state is decoded from mode_i.
  - Mode 0: go to S_CLEAN.
  - Mode 1: go to S_RAND.
  - Mode 2, entered from another mode: go to S_GAP with cnt=0.
  - Mode 3: go to S_CLEAN.
  - A mode change takes effect on the same valid symbol it is sampled with.
- S_RAND: mask = raw when the rate hit holds, else 0. A zero raw is legal, so roughly 1/4 of hits inject nothing when SYM_W=2.
- S_GAP: mask=0, cnt++.
  - When cnt reaches burst_gap_i, go to S_BURST with cnt=0 (transition happens after the gap symbols).
  - burst_gap_i=0 skips the gap.
- S_BURST: mask=nzmask, cnt++. After burst_len_i symbols, go to S_GAP with cnt=0. burst_len_i=0 makes the FSM stay in S_GAP, clean.
- Single-shot:
  - shot_i sets the pending flag (any mode).
  - The next valid symbol uses mask=nzmask ORed with the mode mask, then the flag clears.
  - If shot_i and valid_i coincide, the flag applies to that same symbol.
- Counters:
  - sym_ct increments per valid_i.
  - bad_bit_ct adds popcount(mask).
  - Both saturate at all ones.
  - clr_stats_i has priority over increment; the same-cycle symbol is not counted.
- Reset mid-burst: immediate return to reset values; no residual mask.

Decomposition:
- Package viterbi_chan_pkg: mode enum (CH_CLEAN, CH_RAND, CH_BURST, CH_SHOT), state enum, LFSR polynomial constants per width, popcount function.
- Sub-module chan_lfsr: parametrised Galois LFSR with enable, seed and zero-seed fixup. Instantiated once.

Test Plan:
- Mode 0, 300 valid symbols of alternating 2'b01/2'b10 -> sym_o equals sym_i delayed 1 cycle, err_o=0, sym_ct=300, bad_bit_ct=0.
- Mode 2, gap=3, len=2, 20 symbols -> masks 0,0,0,nz,nz repeating, first nonzero on the 4th symbol; bad_bit_ct equals the summed popcounts.
- Mode 1, rate_i=0, SEED default -> err_o matches the golden LFSR model every symbol. Then rate_i=6 over 6400 symbols -> roughly 100 hits, each hit exactly matching the model.
- Mode 0, shot_i pulsed with valid_i low, then 5 symbols -> only the first following symbol is corrupted; bad_bit_ct is 1 or 2.
- Burst active, rst asserted mid-burst for 1 cycle -> outputs 0 immediately; after release, the LFSR sequence restarts from SEED.
- Counter saturation with CNT_W=4, 20 symbols -> sym_ct sticks at 15. Then clr_stats_i with valid_i high -> counters 0, and that symbol is not counted.

Source files
------------

// File: rtl/viterbi_chan_pkg.sv
// Shared types and constants for the encoder-to-decoder channel model:
// mode/state encodings, LFSR feedback polynomials and a popcount helper.
package viterbi_chan_pkg;

  typedef enum logic [1:0] {
    CH_CLEAN = 2'd0,
    CH_RAND  = 2'd1,
    CH_BURST = 2'd2,
    CH_SHOT  = 2'd3
  } ch_mode_e;

  typedef enum logic [1:0] {
    S_CLEAN = 2'd0,
    S_RAND  = 2'd1,
    S_GAP   = 2'd2,
    S_BURST = 2'd3
  } ch_state_e;

  // Feedback taps without the x^W term, for a left-shifting Galois register.
  localparam logic [31:0] POLY32 = 32'h0040_0007;  // x^32+x^22+x^2+x+1

  function automatic logic [63:0] lfsr_poly(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_0071;
      16:      return 64'h0000_0000_0000_6801;
      24:      return 64'h0000_0000_00C2_0001;
      32:      return {32'h0, POLY32};
      64:      return 64'hB000_0000_0000_0001;
      default: return 64'h0000_0000_0000_0003;
    endcase
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// Galois LFSR with step enable; a zero seed is forced to 1 so the register
// can never lock up in the all-zero state.
module chan_lfsr
  import viterbi_chan_pkg::*;
#(
  parameter int           W    = 32,
  parameter logic [W-1:0] SEED = W'(32'hACE1_2468)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] state_o
);

  localparam logic [W-1:0] SEED_FIX = (SEED == '0) ? W'(1) : SEED;
  localparam logic [W-1:0] POLY     = W'(lfsr_poly(W));

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[W-2:0], 1'b0} ^ (state_q[W-1] ? POLY : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      state_q <= SEED_FIX;
    else if (en_i) state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/viterbi_chan_inj.sv
// Channel model between convolutional encoder and Viterbi decoder: registers
// each symbol, optionally flips bits (random / burst / single shot), and keeps
// saturating symbol and flipped-bit counters.
module viterbi_chan_inj
  import viterbi_chan_pkg::*;
#(
  parameter int                SYM_W  = 2,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_2468),
  parameter int                RATE_W = 5,
  parameter int                CNT_W  = 16,
  parameter int                LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [LEN_W-1:0]  burst_gap_i,
  input  logic              shot_i,
  input  logic              valid_i,
  input  logic [SYM_W-1:0]  sym_i,
  input  logic              clr_stats_i,
  output logic              valid_o,
  output logic [SYM_W-1:0]  sym_o,
  output logic [SYM_W-1:0]  err_o,
  output logic [CNT_W-1:0]  sym_ct_o,
  output logic [CNT_W-1:0]  bad_bit_ct_o
);

  localparam int PC_W = $clog2(SYM_W + 1);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] rate_msk;
  logic              rate_hit;
  logic [SYM_W-1:0]  raw, nzmask, mode_mask, mask;

  ch_state_e         state_q, state_d, eff_st, nxt_st;
  logic [LEN_W-1:0]  cnt_q, cnt_d, eff_cnt, nxt_cnt;
  logic [LEN_W:0]    cnt_inc;

  logic              pend_q, pend_d, shot_eff;
  logic              valid_q;
  logic [SYM_W-1:0]  sym_q, err_q;
  logic [CNT_W-1:0]  sym_ct_q, sym_ct_d, bad_q, bad_d;
  logic [PC_W-1:0]   pc;
  logic [CNT_W:0]    bad_sum;

  chan_lfsr #(.W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (valid_i),
    .state_o(lfsr)
  );

  assign raw    = lfsr[LFSR_W-1 -: SYM_W];
  assign nzmask = (raw == '0) ? SYM_W'(1) : raw;

  always_comb begin
    rate_msk = '0;
    for (int i = 0; i < LFSR_W; i++) rate_msk[i] = (i < int'(rate_i));
  end
  assign rate_hit = ((lfsr & rate_msk) == rate_msk);

  always_comb begin
    eff_st    = S_CLEAN;
    eff_cnt   = '0;
    nxt_st    = S_CLEAN;
    nxt_cnt   = '0;
    mode_mask = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (ch_mode_e'(mode_i))
      CH_RAND:  eff_st = S_RAND;
      CH_BURST: begin
        if (state_q == S_GAP || state_q == S_BURST) begin
          eff_st  = state_q;
          eff_cnt = cnt_q;
        end else begin
          eff_st = S_GAP;
        end
      end
      default:  eff_st = S_CLEAN;
    endcase
    // A gap already served (or a burst whose length was zeroed) is reclassified
    // before this symbol uses it, so gap=0 bursts start on the entry symbol.
    if (eff_st == S_GAP && eff_cnt >= burst_gap_i && burst_len_i != '0) begin
      eff_st  = S_BURST;
      eff_cnt = '0;
    end else if (eff_st == S_BURST && burst_len_i == '0) begin
      eff_st  = S_GAP;
      eff_cnt = '0;
    end
    cnt_inc = {1'b0, eff_cnt} + 1'b1;
    case (eff_st)
      S_RAND: begin
        mode_mask = rate_hit ? raw : '0;
        nxt_st    = S_RAND;
      end
      S_GAP: begin
        if (cnt_inc >= {1'b0, burst_gap_i} && burst_len_i != '0) begin
          nxt_st = S_BURST;
        end else begin
          nxt_st  = S_GAP;
          nxt_cnt = (eff_cnt >= burst_gap_i) ? eff_cnt : cnt_inc[LEN_W-1:0];
        end
      end
      S_BURST: begin
        mode_mask = nzmask;
        if (cnt_inc >= {1'b0, burst_len_i}) begin
          nxt_st = S_GAP;
        end else begin
          nxt_st  = S_BURST;
          nxt_cnt = cnt_inc[LEN_W-1:0];
        end
      end
      default: nxt_st = S_CLEAN;
    endcase
    if (valid_i) begin
      state_d = nxt_st;
      cnt_d   = nxt_cnt;
    end
  end

  // A shot request is held until a valid symbol arrives to carry it.
  assign shot_eff = pend_q | shot_i;
  assign pend_d   = valid_i ? 1'b0 : shot_eff;
  assign mask     = mode_mask | (shot_eff ? nzmask : '0);

  assign pc      = PC_W'(popcount(64'(mask)));
  assign bad_sum = {1'b0, bad_q} + (CNT_W+1)'(pc);

  always_comb begin
    sym_ct_d = sym_ct_q;
    bad_d    = bad_q;
    if (clr_stats_i) begin
      sym_ct_d = '0;
      bad_d    = '0;
    end else if (valid_i) begin
      sym_ct_d = (&sym_ct_q) ? sym_ct_q : sym_ct_q + 1'b1;
      bad_d    = bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_CLEAN;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      sym_q    <= '0;
      err_q    <= '0;
      sym_ct_q <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      valid_q  <= valid_i;
      sym_ct_q <= sym_ct_d;
      bad_q    <= bad_d;
      if (valid_i) begin
        sym_q <= sym_i ^ mask;
        err_q <= mask;
      end
    end
  end

  assign valid_o      = valid_q;
  assign sym_o        = sym_q;
  assign err_o        = err_q;
  assign sym_ct_o     = sym_ct_q;
  assign bad_bit_ct_o = bad_q;

endmodule

// File: tb/tb_viterbi_chan_inj.sv
// Self-checking bench for viterbi_chan_inj: randomized stimulus against a
// behavioural channel model (polynomial LFSR, periodic burst position, shot flag).
module tb_viterbi_chan_inj;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h0040_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_i = 2'd0;
  logic [4:0]  rate_i = 5'd0;
  logic [7:0]  burst_len_i = 8'd0;
  logic [7:0]  burst_gap_i = 8'd0;
  logic        shot_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = 2'd0;
  logic        clr_stats_i = 1'b0;
  logic        valid_o;
  logic [1:0]  sym_o, err_o;
  logic [15:0] sym_ct_o, bad_bit_ct_o;
  logic        v4;
  logic [1:0]  s4, e4;
  logic [3:0]  sc4, bc4;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_lfsr;
  int          m_pos;
  logic [1:0]  m_prev_mode;
  bit          m_pend;
  int          m_ct, m_bad;
  logic [1:0]  exp_sym, exp_err;

  always #5 clk = ~clk;

  viterbi_chan_inj dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .rate_i(rate_i),
    .burst_len_i(burst_len_i), .burst_gap_i(burst_gap_i), .shot_i(shot_i),
    .valid_i(valid_i), .sym_i(sym_i), .clr_stats_i(clr_stats_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
    .sym_ct_o(sym_ct_o), .bad_bit_ct_o(bad_bit_ct_o)
  );

  viterbi_chan_inj #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mode_i(mode_i), .rate_i(rate_i),
    .burst_len_i(burst_len_i), .burst_gap_i(burst_gap_i), .shot_i(shot_i),
    .valid_i(valid_i), .sym_i(sym_i), .clr_stats_i(clr_stats_i),
    .valid_o(v4), .sym_o(s4), .err_o(e4),
    .sym_ct_o(sc4), .bad_bit_ct_o(bc4)
  );

  task automatic model_reset();
    m_lfsr = SEED; m_pos = 0; m_prev_mode = 2'd0; m_pend = 0;
    m_ct = 0; m_bad = 0; exp_sym = 2'd0; exp_err = 2'd0;
  endtask

  // One valid symbol through the channel, from the rules rather than the RTL.
  task automatic model_sym(input logic [1:0] s);
    logic [1:0]  raw, nz, m;
    logic [31:0] low;
    raw = m_lfsr[31:30];
    nz  = (raw == 2'b00) ? 2'b01 : raw;
    m   = 2'b00;
    case (mode_i)
      2'd1: begin
        low = 32'((64'd1 << rate_i) - 64'd1);
        if ((m_lfsr & low) == low) m = raw;
      end
      2'd2: begin
        if (m_prev_mode != 2'd2) m_pos = 0;
        if (burst_len_i != 0 &&
            (m_pos % (int'(burst_gap_i) + int'(burst_len_i))) >= int'(burst_gap_i)) m = nz;
        m_pos++;
      end
      default: ;
    endcase
    if (m_pend || shot_i) m |= nz;
    m_pend = 0;
    m_prev_mode = mode_i;
    m_lfsr = {m_lfsr[30:0], 1'b0} ^ (m_lfsr[31] ? POLY : 32'h0);
    exp_err = m;
    exp_sym = s ^ m;
    if (clr_stats_i) begin
      m_ct = 0; m_bad = 0;
    end else begin
      m_ct  = (m_ct + 1 > 65535) ? 65535 : m_ct + 1;
      m_bad = (m_bad + $countones(m) > 65535) ? 65535 : m_bad + $countones(m);
    end
  endtask

  task automatic send(input logic [1:0] s);
    valid_i = 1'b1;
    sym_i   = s;
    model_sym(s);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    if (shot_i) m_pend = 1;
    if (clr_stats_i) begin m_ct = 0; m_bad = 0; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_chk++;
    if ({valid_o, sym_o, err_o, sym_ct_o, bad_bit_ct_o} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b sym=%b err=%b ct=%0d bad=%0d, want all 0",
               valid_o, sym_o, err_o, sym_ct_o, bad_bit_ct_o);
    end
    n_chk++;
    if ({v4, s4, e4, sc4, bc4} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state_cnt4: got ct=%0d bad=%0d, want 0", sc4, bc4);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    logic [1:0] held;
    mode_i = 2'd0;
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? 2'b01 : 2'b10);
      n_chk++;
      if (valid_o !== 1'b1 || sym_o !== exp_sym || err_o !== exp_err) begin
        n_err++;
        $display("FAIL clean_sym[%0d]: got v=%b sym=%b err=%b, want v=1 sym=%b err=%b",
                 i, valid_o, sym_o, err_o, exp_sym, exp_err);
      end
      if (i == 150) begin
        held = exp_sym;
        for (int k = 0; k < 3; k++) begin
          idle();
          n_chk++;
          if (valid_o !== 1'b0 || sym_o !== held || err_o !== 2'b00) begin
            n_err++;
            $display("FAIL clean_hold[%0d]: got v=%b sym=%b err=%b, want v=0 sym=%b err=00",
                     k, valid_o, sym_o, err_o, held);
          end
        end
      end
    end
    n_chk++;
    if (sym_ct_o !== 16'(m_ct) || bad_bit_ct_o !== 16'(m_bad) || m_ct != 300) begin
      n_err++;
      $display("FAIL clean_counts: got ct=%0d bad=%0d, want ct=300 bad=0", sym_ct_o, bad_bit_ct_o);
    end
  endtask

  task automatic test_burst();
    int first_nz;
    mode_i = 2'd2; burst_gap_i = 8'd3; burst_len_i = 8'd2;
    first_nz = -1;
    for (int i = 0; i < 20; i++) begin
      send(2'($urandom));
      if (first_nz < 0 && err_o != 2'b00) first_nz = i;
      n_chk++;
      if (sym_o !== exp_sym || err_o !== exp_err) begin
        n_err++;
        $display("FAIL burst_sym[%0d]: got sym=%b err=%b, want sym=%b err=%b",
                 i, sym_o, err_o, exp_sym, exp_err);
      end
    end
    n_chk++;
    if (first_nz != 3) begin
      n_err++;
      $display("FAIL burst_first_err: got index %0d, want 3", first_nz);
    end
    n_chk++;
    if (bad_bit_ct_o !== 16'(m_bad)) begin
      n_err++;
      $display("FAIL burst_bad_ct: got %0d, want %0d", bad_bit_ct_o, m_bad);
    end
    for (int r = 0; r < 6; r++) begin
      mode_i = 2'd0;
      send(2'($urandom));
      mode_i = 2'd2;
      burst_gap_i = 8'($urandom_range(0, 4));
      burst_len_i = 8'($urandom_range(0, 3));
      for (int i = 0; i < 15; i++) begin
        send(2'($urandom));
        n_chk++;
        if (sym_o !== exp_sym || err_o !== exp_err) begin
          n_err++;
          $display("FAIL burst_rand[g=%0d l=%0d][%0d]: got sym=%b err=%b, want sym=%b err=%b",
                   burst_gap_i, burst_len_i, i, sym_o, err_o, exp_sym, exp_err);
        end
      end
    end
  endtask

  task automatic test_random();
    int hits;
    logic [1:0] held;
    mode_i = 2'd1; rate_i = 5'd0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        held = exp_sym;
        idle();
        n_chk++;
        if (valid_o !== 1'b0 || sym_o !== held) begin
          n_err++;
          $display("FAIL rand0_hold[%0d]: got v=%b sym=%b, want v=0 sym=%b", i, valid_o, sym_o, held);
        end
      end else begin
        send(2'($urandom));
        n_chk++;
        if (valid_o !== 1'b1 || sym_o !== exp_sym || err_o !== exp_err) begin
          n_err++;
          $display("FAIL rand0_sym[%0d]: got sym=%b err=%b, want sym=%b err=%b",
                   i, sym_o, err_o, exp_sym, exp_err);
        end
      end
    end
    rate_i = 5'd6;
    hits = 0;
    for (int i = 0; i < 6400; i++) begin
      send(2'($urandom));
      if (err_o != 2'b00) hits++;
      n_chk++;
      if (sym_o !== exp_sym || err_o !== exp_err) begin
        n_err++;
        $display("FAIL rand6_sym[%0d]: got sym=%b err=%b, want sym=%b err=%b",
                 i, sym_o, err_o, exp_sym, exp_err);
      end
    end
    n_chk++;
    if (hits < 30 || hits > 140) begin
      n_err++;
      $display("FAIL rand6_rate: got %0d corrupted symbols, want about 75 (30..140)", hits);
    end
  endtask

  task automatic test_shot();
    mode_i = 2'd0;
    clr_stats_i = 1'b1; idle(); clr_stats_i = 1'b0;
    shot_i = 1'b1; idle(); shot_i = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      send(2'($urandom));
      n_chk++;
      if (sym_o !== exp_sym || err_o !== exp_err || (i == 0) !== (err_o != 2'b00)) begin
        n_err++;
        $display("FAIL shot_sym[%0d]: got sym=%b err=%b, want sym=%b err=%b",
                 i, sym_o, err_o, exp_sym, exp_err);
      end
    end
    n_chk++;
    if (bad_bit_ct_o !== 16'(m_bad) || m_bad < 1 || m_bad > 2) begin
      n_err++;
      $display("FAIL shot_bad_ct: got %0d, want %0d (1 or 2)", bad_bit_ct_o, m_bad);
    end
    shot_i = 1'b1; send(2'b00); shot_i = 1'b0;
    n_chk++;
    if (err_o !== exp_err || err_o == 2'b00) begin
      n_err++;
      $display("FAIL shot_coincident: got err=%b, want %b (nonzero)", err_o, exp_err);
    end
    send(2'b11);
    n_chk++;
    if (err_o !== 2'b00 || sym_o !== 2'b11) begin
      n_err++;
      $display("FAIL shot_after: got sym=%b err=%b, want sym=11 err=00", sym_o, err_o);
    end
  endtask

  task automatic test_reset_mid();
    mode_i = 2'd0; send(2'b00);
    mode_i = 2'd2; burst_gap_i = 8'd0; burst_len_i = 8'd5;
    for (int i = 0; i < 3; i++) send(2'b00);
    n_chk++;
    if (err_o === 2'b00) begin
      n_err++;
      $display("FAIL rstmid_pre: got err=%b, want nonzero burst mask", err_o);
    end
    valid_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({valid_o, sym_o, err_o, sym_ct_o, bad_bit_ct_o} !== 37'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b sym=%b err=%b ct=%0d bad=%0d, want all 0",
               valid_o, sym_o, err_o, sym_ct_o, bad_bit_ct_o);
    end
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b1;
    model_reset();
    mode_i = 2'd1; rate_i = 5'd0;
    @(negedge clk);
    n_chk++;
    if (err_o !== 2'b00 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_residual: got v=%b err=%b, want v=0 err=00", valid_o, err_o);
    end
    for (int i = 0; i < 32; i++) begin
      send(2'($urandom));
      n_chk++;
      if (sym_o !== exp_sym || err_o !== exp_err) begin
        n_err++;
        $display("FAIL rstmid_lfsr[%0d]: got sym=%b err=%b, want sym=%b err=%b",
                 i, sym_o, err_o, exp_sym, exp_err);
      end
    end
  endtask

  task automatic test_saturation();
    mode_i = 2'd2; burst_gap_i = 8'd0; burst_len_i = 8'd200;
    clr_stats_i = 1'b1; idle(); clr_stats_i = 1'b0;
    for (int i = 0; i < 20; i++) send(2'($urandom));
    n_chk++;
    if (sc4 !== 4'd15 || bc4 !== 4'd15) begin
      n_err++;
      $display("FAIL sat_cnt4: got ct=%0d bad=%0d, want 15 15", sc4, bc4);
    end
    n_chk++;
    if (sym_ct_o !== 16'(m_ct) || bad_bit_ct_o !== 16'(m_bad) || m_ct != 20) begin
      n_err++;
      $display("FAIL sat_cnt16: got ct=%0d bad=%0d, want ct=%0d bad=%0d",
               sym_ct_o, bad_bit_ct_o, m_ct, m_bad);
    end
    clr_stats_i = 1'b1; send(2'b10); clr_stats_i = 1'b0;
    n_chk++;
    if (sc4 !== 4'd0 || bc4 !== 4'd0 || sym_ct_o !== 16'd0 || bad_bit_ct_o !== 16'd0) begin
      n_err++;
      $display("FAIL sat_clear: got ct4=%0d bad4=%0d ct=%0d bad=%0d, want all 0",
               sc4, bc4, sym_ct_o, bad_bit_ct_o);
    end
    n_chk++;
    if (sym_o !== exp_sym || err_o !== exp_err) begin
      n_err++;
      $display("FAIL sat_clear_data: got sym=%b err=%b, want sym=%b err=%b",
               sym_o, err_o, exp_sym, exp_err);
    end
    send(2'b01);
    n_chk++;
    if (sym_ct_o !== 16'd1 || sc4 !== 4'd1 || bad_bit_ct_o !== 16'(m_bad)) begin
      n_err++;
      $display("FAIL sat_after_clear: got ct=%0d ct4=%0d bad=%0d, want ct=1 ct4=1 bad=%0d",
               sym_ct_o, sc4, bad_bit_ct_o, m_bad);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_clean();
    test_burst();
    test_random();
    test_shot();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
